// File: rtl/ring_mon_pkg.sv
// Shared types and helpers for the ring counter phase monitor.
package ring_mon_pkg;

   typedef enum logic [1:0] {
      StUnlocked,
      StAcquire,
      StLocked,
      StFault
   } mon_state_e;

   // Widest ring the rotate helper supports.
   localparam int unsigned MaxW = 64;

   function automatic int unsigned idx_w(input int unsigned n);
      int unsigned w;
      w = $clog2(n);
      return (w == 0) ? 1 : w;
   endfunction

   // Rotate left by one within the low n bits, matching Q[i] <= Q[i-1].
   function automatic logic [MaxW-1:0] rotl1(input logic [MaxW-1:0] v, input int unsigned n);
      logic [MaxW-1:0] mask;
      mask = ~({MaxW{1'b1}} << n);
      return ((v << 1) | (v >> (n - 1))) & mask;
   endfunction

endpackage

// File: rtl/onehot_enc.sv
// Combinational one-hot to binary encoder with a single-bit-set flag.
module onehot_enc
   import ring_mon_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned IdxW = idx_w(N)
) (
   input  logic [N-1:0]    vec,
   output logic [IdxW-1:0] idx,
   output logic            is_onehot
);

   localparam logic [N-1:0] One = N'(1);

   always_comb begin
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (vec[i]) idx = idx | IdxW'(i);
      end
   end

   assign is_onehot = (vec != '0) && ((vec & (vec - One)) == '0);

endmodule

// File: rtl/ring_phase_monitor.sv
// Tracks a one-hot ring counter: phase index, rotation checking, lock/fault state,
// revolution and fault counters, and a resync request while faulted.
module ring_phase_monitor
   import ring_mon_pkg::*;
#(
   parameter int unsigned N        = 4,
   parameter int unsigned REV_W    = 8,
   parameter int unsigned ERR_W    = 4,
   parameter int unsigned LOCK_CNT = 2,
   localparam int unsigned IdxW    = idx_w(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N-1:0]     ring_q,
   input  logic             clr_err,
   output logic [IdxW-1:0]  idx,
   output logic             idx_valid,
   output logic             wrap,
   output logic [REV_W-1:0] rev_cnt,
   output logic             locked,
   output logic             fault,
   output logic             resync_req,
   output logic             sticky_err,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
   localparam logic [MatchW-1:0] LockLast = MatchW'(LOCK_CNT - 1);
   localparam logic [N-1:0] One = N'(1);

   mon_state_e        state_q, state_d;
   logic [N-1:0]      prev_q;
   logic [MatchW-1:0] match_q;
   logic [IdxW-1:0]   enc_idx;
   logic              onehot;
   logic [N-1:0]      expected;
   logic              good;

   onehot_enc #(
      .N (N)
   ) u_enc (
      .vec       (ring_q),
      .idx       (enc_idx),
      .is_onehot (onehot)
   );

   assign expected = N'(rotl1(MaxW'(prev_q), N));
   assign good     = onehot && (ring_q == expected);

   always_comb begin
      state_d = state_q;
      if (en) begin
         unique case (state_q)
            StUnlocked: if (onehot) state_d = StAcquire;
            StAcquire: begin
               if (good) begin
                  if (match_q == LockLast) state_d = StLocked;
               end else if (!onehot) begin
                  state_d = StUnlocked;
               end
            end
            StLocked:   if (!good) state_d = StFault;
            StFault:    if (ring_q == One) state_d = StAcquire;
            default:    state_d = StUnlocked;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StUnlocked;
         prev_q     <= '0;
         match_q    <= '0;
         idx        <= '0;
         idx_valid  <= 1'b0;
         wrap       <= 1'b0;
         rev_cnt    <= '0;
         locked     <= 1'b0;
         fault      <= 1'b0;
         resync_req <= 1'b0;
         sticky_err <= 1'b0;
         err_cnt    <= '0;
      end else begin
         state_q    <= state_d;
         locked     <= (state_d == StLocked);
         fault      <= (state_d == StFault);
         resync_req <= (state_d == StFault);
         wrap       <= 1'b0;
         if (clr_err) begin
            sticky_err <= 1'b0;
            err_cnt    <= '0;
         end
         if (en) begin
            prev_q <= ring_q;
            if (onehot) begin
               idx       <= enc_idx;
               idx_valid <= 1'b1;
            end else begin
               idx_valid <= 1'b0;
            end
            // Entering ACQUIRE restarts the count from the new sample.
            if (state_d == StAcquire && state_q != StAcquire) begin
               match_q <= '0;
            end else if (state_q == StAcquire) begin
               match_q <= good ? match_q + MatchW'(1) : '0;
            end
            if (state_q == StLocked) begin
               if (good && prev_q[N-1] && ring_q[0]) begin
                  wrap    <= 1'b1;
                  rev_cnt <= rev_cnt + REV_W'(1);
               end
               // A new fault beats a same-edge clear.
               if (!good) begin
                  sticky_err <= 1'b1;
                  if (clr_err)       err_cnt <= ERR_W'(1);
                  else if (!(&err_cnt)) err_cnt <= err_cnt + ERR_W'(1);
               end
            end
         end
      end
   end

endmodule
